// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a fixed-latency FP ALU: accepts one command at a time,
// waits LATENCY edges for the result, and holds the response until consumed.
module fpu_issue_ctrl #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_great,
    input  logic        alu_less,
    input  logic        alu_equal,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [2:0] OP_MAX_LEGAL = 3'd4;
    localparam logic [3:0] LAT_LOAD     = 4'(LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_count_q, rsp_count_d;

    logic op_legal;
    assign op_legal = (cmd_op <= OP_MAX_LEGAL);

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case below can leave a signal unassigned (no latch).
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        rsp_count_d = rsp_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (op_legal) begin
                        alu_op_d   = cmd_op;
                        alu_a_d    = cmd_a;
                        alu_b_d    = cmd_b;
                        wait_cnt_d = LAT_LOAD;
                        state_d    = WAIT;
                    end else begin
                        // Illegal ops never reach the ALU; its drive stays put.
                        state_d = ERR;
                    end
                end
            end

            WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d  = 4'd0;
                    rsp_data_d  = alu_out;
                    rsp_flags_d = {alu_great, alu_less, alu_equal};
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            ERR: begin
                rsp_data_d  = 32'd0;
                rsp_flags_d = 3'd0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_count_d = rsp_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the async reset clears all state, including data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            alu_op_q    <= 3'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_flags_q <= 3'd0;
            rsp_err_q   <= 1'b0;
            rsp_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: the ALU is modelled by driving alu_out
// and the compare flags directly; expected values are hand-computed constants.
module tb_fpu_issue_ctrl;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out;
    logic        alu_great, alu_less, alu_equal;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] rsp_count;

    int vectors = 0;
    int errors  = 0;

    fpu_issue_ctrl #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_great (alu_great),
        .alu_less  (alu_less),
        .alu_equal (alu_equal),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .rsp_count (rsp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_cnt;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        alu_out   = 32'd0;
        alu_great = 1'b0;
        alu_less  = 1'b0;
        alu_equal = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_count", 32'(rsp_count), 32'd0);
        check("rst_alu_a",     alu_a,          32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);

        // Add, accepted on the very first edge after reset release
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 32'h3F80_0000;
        cmd_b     = 32'h4000_0000;
        alu_out   = 32'h4040_0000;
        alu_less  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("add_cmd_ready", 32'(cmd_ready), 32'd0);
        check("add_alu_op",    32'(alu_op),    32'd0);
        check("add_alu_a",     alu_a,          32'h3F80_0000);
        check("add_alu_b",     alu_b,          32'h4000_0000);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("add_early_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp_data",  rsp_data,       32'h4040_0000);
        check("add_rsp_err",   32'(rsp_err),   32'd0);
        check("add_rsp_flags", 32'(rsp_flags), 32'b010);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("add_hs_valid",     32'(rsp_valid), 32'd0);
        check("add_hs_count",     32'(rsp_count), 32'd1);
        check("add_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("add_hs_data_keep", rsp_data,       32'h4040_0000);

        // Compare, with a second command held on cmd_valid while busy
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = 32'h4000_0000;
        cmd_b     = 32'h3F80_0000;
        alu_out   = 32'h0000_0001;
        alu_great = 1'b1;
        alu_less  = 1'b0;
        alu_equal = 1'b0;
        tick();
        cmd_a  = 32'hDEAD_BEEF;
        cmd_op = 3'd2;
        for (int i = 0; i < LAT; i++) tick();
        check("cmp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("cmp_rsp_flags", 32'(rsp_flags), 32'b100);
        check("cmp_rsp_data",  rsp_data,       32'h0000_0001);
        alu_out   = 32'h1234_5678;
        alu_great = 1'b0;
        alu_equal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cmp_hold_valid", 32'(rsp_valid), 32'd1);
            check("cmp_hold_flags", 32'(rsp_flags), 32'b100);
            check("cmp_hold_data",  rsp_data,       32'h0000_0001);
            check("cmp_hold_ready", 32'(cmd_ready), 32'd0);
        end
        check("cmp_alu_a_held", alu_a,        32'h4000_0000);
        check("cmp_alu_op_held", 32'(alu_op), 32'd4);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("cmp_hs_valid", 32'(rsp_valid), 32'd0);
        check("cmp_hs_count", 32'(rsp_count), 32'd2);

        // rsp_ready while idle has no effect
        tick();
        rsp_ready = 1'b0;
        check("idle_ready_count", 32'(rsp_count), 32'd2);
        check("idle_ready_valid", 32'(rsp_valid), 32'd0);

        // Illegal opcode
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_a     = 32'h1111_1111;
        cmd_b     = 32'h2222_2222;
        alu_out   = 32'hAAAA_AAAA;
        alu_great = 1'b1;
        alu_less  = 1'b1;
        alu_equal = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("ill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("ill_early_valid", 32'(rsp_valid), 32'd0);
        check("ill_alu_op", 32'(alu_op), 32'd4);
        check("ill_alu_a",  alu_a,       32'h4000_0000);
        check("ill_alu_b",  alu_b,       32'h3F80_0000);
        tick();
        check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ill_rsp_err",   32'(rsp_err),   32'd1);
        check("ill_rsp_data",  rsp_data,       32'd0);
        check("ill_rsp_flags", 32'(rsp_flags), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("ill_hs_count", 32'(rsp_count), 32'd3);
        check("ill_hs_valid", 32'(rsp_valid), 32'd0);

        // Back-to-back traffic across the counter wrap
        force dut.rsp_count_q = 16'hFFFE;
        #1;
        release dut.rsp_count_q;
        exp_cnt   = 16'hFFFE;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_a     = 32'h4080_0000;
        cmd_b     = 32'h3F80_0000;
        alu_out   = 32'h4040_0000;
        alu_great = 1'b0;
        alu_less  = 1'b0;
        alu_equal = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("b2b_accept", 32'(cmd_ready), 32'd0);
            for (int i = 1; i < LAT; i++) begin
                tick();
                check("b2b_early_valid", 32'(rsp_valid), 32'd0);
            end
            tick();
            check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            check("b2b_hs_valid", 32'(rsp_valid), 32'd0);
            check("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
            check("b2b_count", 32'(rsp_count), 32'(exp_cnt));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;

        // Reset two cycles after acceptance
        tick();
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_a     = 32'h4040_0000;
        cmd_b     = 32'h4000_0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_rsp_count", 32'(rsp_count), 32'd0);
        check("rstw_alu_a",     alu_a,           32'd0);
        check("rstw_alu_op",    32'(alu_op),     32'd0);
        check("rstw_cmd_ready", 32'(cmd_ready),  32'd1);
        check("rstw_rsp_data",  rsp_data,        32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            check("rstw_no_rsp",   32'(rsp_valid), 32'd0);
            check("rstw_count_0",  32'(rsp_count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
